// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate extractor/extender for the 64-bit LEGv8 datapath.
//   It takes a raw instruction and a format select, then extracts and extends
//   the immediate for the I/D/B/CB/IW formats and applies the format's shift.
//   The result sits in a registered output stage. A one-entry skid register
//   absorbs back-pressure, so items are never dropped or reordered.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous, active-low reset
//   in_valid   instr/fmt/tag_in valid this cycle
//   in_ready   block can accept (driven only by state, never by out_ready)
//   instr      raw 32-bit instruction word
//   fmt        0=I 1=D 2=B 3=CB 4=IW 5..7=illegal
//   tag_in     side-band tag carried alongside the immediate
//   out_valid  imm_out/tag_out/err valid
//   out_ready  consumer accepts this cycle
//   imm_out    extended immediate (0 when err)
//   tag_out    tag matching imm_out
//   err        illegal format, or IW half-word shift beyond OUT_W
module imm_extend_pipe #(
  parameter int OUT_W    = 64,
  parameter int TAG_W    = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       fmt,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_D  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_CB = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;

  // Opcode bits above the B-format field are not used by any extractor.
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  // Extended fields, all in OUT_W bits before shifting so the shift drops
  // bits past OUT_W-1 instead of saturating.
  logic [OUT_W-1:0] i_ext, d_ext, b_ext, cb_ext, iw_base;
  assign i_ext   = {{(OUT_W-12){1'b0}}, instr[21:10]};
  assign d_ext   = {{(OUT_W-9){instr[20]}}, instr[20:12]};
  assign b_ext   = {{(OUT_W-26){instr[25]}}, instr[25:0]} << BR_SHIFT;
  assign cb_ext  = {{(OUT_W-19){instr[23]}}, instr[23:5]} << BR_SHIFT;
  assign iw_base = {{(OUT_W-16){1'b0}}, instr[20:5]};

  // One lane per half-word position; a lane "fits" only if the whole
  // 16-bit field lands inside OUT_W bits.
  logic [OUT_W-1:0] iw_lane [4];
  logic [3:0]       iw_fits;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_iw_lane
      assign iw_lane[gi] = iw_base << (16 * gi);
      assign iw_fits[gi] = ((16 * gi + 16) <= OUT_W);
    end
  endgenerate

  logic [OUT_W-1:0] imm_next;
  logic             err_next;

  always_comb begin
    imm_next = '0;
    err_next = 1'b0;
    case (fmt)
      FMT_I:  imm_next = i_ext;
      FMT_D:  imm_next = d_ext;
      FMT_B:  imm_next = b_ext;
      FMT_CB: imm_next = cb_ext;
      FMT_IW: begin
        if (iw_fits[instr[22:21]]) imm_next = iw_lane[instr[22:21]];
        else                       err_next = 1'b1;
      end
      default: err_next = 1'b1;
    endcase
  end

  // Main output stage (m_*) and skid stage (s_*).
  logic             m_valid_reg, s_valid_reg;
  logic [OUT_W-1:0] m_imm_reg,   s_imm_reg;
  logic [TAG_W-1:0] m_tag_reg,   s_tag_reg;
  logic             m_err_reg,   s_err_reg;

  logic accept, drain;
  assign accept = in_valid && in_ready;
  assign drain  = m_valid_reg && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_reg <= 1'b0;
      m_imm_reg   <= '0;
      m_tag_reg   <= '0;
      m_err_reg   <= 1'b0;
      s_valid_reg <= 1'b0;
      s_imm_reg   <= '0;
      s_tag_reg   <= '0;
      s_err_reg   <= 1'b0;
    end else if (!m_valid_reg || drain) begin
      // Output stage is free this cycle. A full skid always has priority;
      // in_ready is low then, so no new item can arrive at the same time.
      if (s_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_imm_reg   <= s_imm_reg;
        m_tag_reg   <= s_tag_reg;
        m_err_reg   <= s_err_reg;
        s_valid_reg <= 1'b0;
      end else if (accept) begin
        m_valid_reg <= 1'b1;
        m_imm_reg   <= imm_next;
        m_tag_reg   <= tag_in;
        m_err_reg   <= err_next;
      end else begin
        m_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new item in the skid register.
      s_valid_reg <= 1'b1;
      s_imm_reg   <= imm_next;
      s_tag_reg   <= tag_in;
      s_err_reg   <= err_next;
    end
  end

  // Derived from a flop only, so the producer never sees a path from out_ready.
  assign in_ready  = !s_valid_reg;
  assign out_valid = m_valid_reg;
  assign imm_out   = m_imm_reg;
  assign tag_out   = m_tag_reg;
  assign err       = m_err_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe (OUT_W=64, TAG_W=5, BR_SHIFT=2):
//   reset values, per-format extraction, stall/skid ordering, a patterned
//   stream against a queue of expected items, and reset while stalled.
module tb_imm_extend_pipe;
  localparam int OUT_W = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic [TAG_W-1:0] tag_out;
  logic             err;

  int vectors     = 0;
  int miscompares = 0;

  imm_extend_pipe #(.OUT_W(OUT_W), .TAG_W(TAG_W), .BR_SHIFT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .fmt       (fmt),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .tag_out   (tag_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] f, input logic [31:0] i,
                       input logic [TAG_W-1:0] t, input logic v, input logic r);
    fmt = f; instr = i; tag_in = t; in_valid = v; out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(3'd0, 32'h0, '0, 1'b0, 1'b0);
    #3;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_out !== '0 ||
        tag_out !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b imm=%h tag=%h err=%b required 0 1 0 0 0",
               out_valid, in_ready, imm_out, tag_out, err);
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: out_valid=%b required 0", out_valid);
    end
  endtask

  // Back-to-back items with out_ready=1: each one must appear the cycle
  // after it is offered, so this also covers 1 item/cycle throughput.
  task automatic test_formats();
    logic [2:0]       f_t   [13];
    logic [31:0]      i_t   [13];
    logic [OUT_W-1:0] e_t   [13];
    logic             err_t [13];
    f_t[0]  = 3'd1; i_t[0]  = 32'h001F_F000; e_t[0]  = 64'hFFFF_FFFF_FFFF_FFFF; err_t[0]  = 1'b0;
    f_t[1]  = 3'd1; i_t[1]  = 32'h000F_F000; e_t[1]  = 64'h0000_0000_0000_00FF; err_t[1]  = 1'b0;
    f_t[2]  = 3'd0; i_t[2]  = 32'h003F_FC00; e_t[2]  = 64'h0000_0000_0000_0FFF; err_t[2]  = 1'b0;
    f_t[3]  = 3'd2; i_t[3]  = 32'h03FF_FFFF; e_t[3]  = 64'hFFFF_FFFF_FFFF_FFFC; err_t[3]  = 1'b0;
    f_t[4]  = 3'd2; i_t[4]  = 32'h0000_0001; e_t[4]  = 64'h0000_0000_0000_0004; err_t[4]  = 1'b0;
    f_t[5]  = 3'd3; i_t[5]  = 32'h0000_0200; e_t[5]  = 64'h0000_0000_0000_0040; err_t[5]  = 1'b0;
    f_t[6]  = 3'd3; i_t[6]  = 32'h00FF_FFE0; e_t[6]  = 64'hFFFF_FFFF_FFFF_FFFC; err_t[6]  = 1'b0;
    f_t[7]  = 3'd4; i_t[7]  = 32'h0057_DDE0; e_t[7]  = 64'h0000_BEEF_0000_0000; err_t[7]  = 1'b0;
    f_t[8]  = 3'd4; i_t[8]  = 32'h0062_4680; e_t[8]  = 64'h1234_0000_0000_0000; err_t[8]  = 1'b0;
    f_t[9]  = 3'd6; i_t[9]  = 32'hFFFF_FFFF; e_t[9]  = 64'h0;                   err_t[9]  = 1'b1;
    f_t[10] = 3'd5; i_t[10] = 32'h1234_5678; e_t[10] = 64'h0;                   err_t[10] = 1'b1;
    f_t[11] = 3'd7; i_t[11] = 32'h0000_0000; e_t[11] = 64'h0;                   err_t[11] = 1'b1;
    f_t[12] = 3'd0; i_t[12] = 32'hFFC0_03FF; e_t[12] = 64'h0;                   err_t[12] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive(f_t[k], i_t[k], TAG_W'(k + 3), 1'b1, 1'b1);
      step();
      vectors++;
      if (out_valid !== 1'b1 || imm_out !== e_t[k] || err !== err_t[k] ||
          tag_out !== TAG_W'(k + 3)) begin
        miscompares++;
        $display("FAIL format_%0d: valid=%b imm=%h err=%b tag=%0d required 1 %h %b %0d",
                 k, out_valid, imm_out, err, tag_out, e_t[k], err_t[k], k + 3);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL format_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  // Tags 1,2,3 with the consumer stalled: 1 in M, 2 in skid, 3 must wait.
  task automatic test_stall_order();
    drive(3'd0, 32'h0000_0400, 5'd1, 1'b1, 1'b0);
    step();
    vectors++;
    if (out_valid !== 1'b1 || tag_out !== 5'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first: valid=%b tag=%0d in_ready=%b required 1 1 1",
               out_valid, tag_out, in_ready);
    end
    drive(3'd0, 32'h0000_0800, 5'd2, 1'b1, 1'b0);
    step();
    vectors++;
    if (tag_out !== 5'd1 || imm_out !== 64'h1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_full: tag=%0d imm=%h in_ready=%b required 1 1 0",
               tag_out, imm_out, in_ready);
    end
    drive(3'd0, 32'h0000_0C00, 5'd3, 1'b1, 1'b0);
    step();
    vectors++;
    if (tag_out !== 5'd1 || imm_out !== 64'h1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold: tag=%0d imm=%h in_ready=%b valid=%b required 1 1 0 1",
               tag_out, imm_out, in_ready, out_valid);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || tag_out !== 5'd2 || imm_out !== 64'h2 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_2: valid=%b tag=%0d imm=%h in_ready=%b required 1 2 2 1",
               out_valid, tag_out, imm_out, in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || tag_out !== 5'd3 || imm_out !== 64'h3) begin
      miscompares++;
      $display("FAIL release_3: valid=%b tag=%0d imm=%h required 1 3 3",
               out_valid, tag_out, imm_out);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_empty: out_valid=%b required 0", out_valid);
    end
  endtask

  // Patterned in_valid/out_ready stream of D-format items; a queue holds the
  // expected sign-extended immediates in acceptance order.
  task automatic test_stream();
    localparam int N = 300;
    logic [OUT_W-1:0] q_imm [$];
    logic [TAG_W-1:0] q_tag [$];
    logic [31:0]      vpat = 32'hB5E3_7A9D;
    logic [31:0]      rpat = 32'h6D2B_F1C7;
    logic [8:0]       k9;
    logic [OUT_W-1:0] exp_imm;
    logic [TAG_W-1:0] exp_tag;
    int sent = 0, got = 0, cyc = 0, bad = 0;
    while (got < N && cyc < 4000) begin
      k9 = sent[8:0];
      drive(3'd1, {11'b0, k9, 12'b0}, sent[4:0], (sent < N) && vpat[cyc % 32],
            rpat[(cyc * 7) % 32]);
      #1;
      if (out_valid && out_ready) begin
        if (q_imm.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: tag=%0d imm=%h required no output", tag_out, imm_out);
        end else begin
          exp_imm = q_imm.pop_front();
          exp_tag = q_tag.pop_front();
          if (imm_out !== exp_imm || tag_out !== exp_tag || err !== 1'b0) begin
            bad++;
            $display("FAIL stream_item_%0d: imm=%h tag=%0d err=%b required %h %0d 0",
                     got, imm_out, tag_out, err, exp_imm, exp_tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_imm.push_back({{(OUT_W-9){k9[8]}}, k9});
        q_tag.push_back(sent[4:0]);
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0 || got != N) begin
      miscompares++;
      $display("FAIL stream: delivered=%0d bad=%0d required %0d delivered 0 bad", got, bad, N);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midstall();
    drive(3'd0, 32'h0000_2400, 5'd9, 1'b1, 1'b0);
    step();
    drive(3'd0, 32'h0000_2800, 5'd10, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== 5'd9) begin
      miscompares++;
      $display("FAIL midstall_full: in_ready=%b valid=%b tag=%0d required 0 1 9",
               in_ready, out_valid, tag_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm_out !== '0 || tag_out !== '0) begin
      miscompares++;
      $display("FAIL midstall_reset: valid=%b in_ready=%b imm=%h tag=%0d required 0 1 0 0",
               out_valid, in_ready, imm_out, tag_out);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midstall_dropped: out_valid=%b tag=%0d required 0", out_valid, tag_out);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_stall_order();
    test_stream();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
